// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - fully-associative branch target buffer with FIFO replacement
module branch_target_buffer #(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_IF,
    input  logic [31:0] pc_EXE,
    input  logic [31:0] target_EXE,
    input  logic [6:0]  opcode_EXE,
    input  logic        jump_sel,
    input  logic        Istall,
    input  logic        Dstall,
    input  logic        wfi_stall,
    output logic        btb_hit,
    output logic [31:0] btb_target
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [ENTRIES-1:0] valid;
    logic [29:0]        tags    [ENTRIES];
    logic [29:0]        targets [ENTRIES];
    logic [IDX_W-1:0]   rp;

    logic               stall;
    logic               update_en;
    logic               upd_hit;
    logic [IDX_W-1:0]   upd_idx;
    logic [IDX_W-1:0]   wr_idx;

    // Word-alignment bits carry no information for the BTB.
    logic unused_low_bits;
    assign unused_low_bits = ^{pc_IF[1:0], pc_EXE[1:0], target_EXE[1:0]};

    assign stall     = Istall | Dstall | wfi_stall;
    assign update_en = !stall && jump_sel && (opcode_EXE == OPC_BRANCH);

    // Fetch lookup: reads only stored state, so writes appear one cycle later.
    always_comb begin
        btb_hit    = 1'b0;
        btb_target = 32'h0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tags[i] == pc_IF[31:2]) begin
                btb_hit    = 1'b1;
                btb_target = {targets[i], 2'b00};
            end
        end
    end

    // Find an existing entry for the EXE branch so a re-update never duplicates a tag.
    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tags[i] == pc_EXE[31:2]) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
        wr_idx = upd_hit ? upd_idx : rp;
    end

    // Valid bits and FIFO pointer; reset dominates stall and update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            rp    <= '0;
        end else if (update_en && !upd_hit) begin
            valid[rp] <= 1'b1;
            rp        <= (rp == IDX_W'(ENTRIES - 1)) ? '0 : rp + 1'b1;
        end
    end

    // Tag/target payload; left unreset since valid gates every use.
    always_ff @(posedge clk) begin
        if (!rst && update_en) begin
            tags[wr_idx]    <= pc_EXE[31:2];
            targets[wr_idx] <= target_EXE[31:2];
        end
    end

endmodule
